fir_mac_arbiter: RTL and testbench
==================================

Name: fir_mac_arbiter

Overview:
- Shares one quantized multiply-accumulate datapath between NUM_REQ FIR channel engines, e.g. the left and right audio FIR filters of the FM demodulator.
- Each requester gets the MAC for one burst of TAPS operand pairs.
- A burst produces one dot product, DEQUANTIZE(a*b) summed over TAPS pairs, which is returned to that requester.
- Requesters are served round-robin.

Parameters:
- NUM_REQ, 2: number of requesting FIR engines (2..8).
- DATA_WIDTH, 32: operand, accumulator and result width, signed two's complement.
- TAPS, 32: operand pairs per burst (2..256).
- FRAC_BITS, 10: fixed-point fraction bits removed after each multiply.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: reset, asynchronous, active-high.
- req, in, NUM_REQ: req[i] high means requester i presents a valid operand pair this cycle.
- a_in, in, NUM_REQ*DATA_WIDTH: sample operand, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_in, in, NUM_REQ*DATA_WIDTH: coefficient operand, same packing as a_in.
- grant, out, NUM_REQ: one-hot owner of the MAC, held for the whole burst.
- op_ack, out, NUM_REQ: op_ack[i] high means requester i's pair is consumed at this clock edge.
- result, out, DATA_WIDTH: dot product of the completed burst.
- result_valid, out, NUM_REQ: one-hot; result is valid for the flagged requester.
- result_ack, in, NUM_REQ: requester i accepts the result.

Behaviour:
- Reset values: grant=0, op_ack=0, result=0, result_valid=0; accumulator=0; tap counter=0; round-robin pointer=0; state IDLE.
- State IDLE:
  - If any req bit is high, pick the first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - Register that winner as g, clear accumulator and counter, go to MAC.
  - grant[g] rises on the cycle after IDLE samples req.
- State MAC:
  - op_ack[g] = req[g], combinational.
  - On each acked cycle: the registered product stage latches DEQUANTIZE(a_g*b_g) and counter increments.
  - Any product registered on the previous cycle is added to the accumulator.
  - req[g] low means a stall: no ack, no count, and no product is added on the following cycle.
  - When the TAPS-th pair is acked, go to DRAIN.
- State DRAIN: add the last product. Go to RESULT.
- State RESULT:
  - result_valid[g]=1 and result=accumulator; both hold stable until result_ack[g] is sampled high.
  - On that edge: result_valid=0, grant=0, pointer=(g+1) mod NUM_REQ, go to IDLE.
- Arithmetic:
  - Full 2*DATA_WIDTH-bit signed product.
  - If the product is negative, add 2^FRAC_BITS-1 before shifting (round toward zero).
  - Arithmetic shift right by FRAC_BITS, then truncate to DATA_WIDTH.
  - Accumulation wraps modulo 2^DATA_WIDTH; no saturation.
- Latency with no stalls: result_valid rises TAPS+1 cycles after grant rises. Each stall cycle adds one.
- Throughput: one pair per cycle. Back-to-back bursts have at least 1 IDLE cycle between them.
- Requests from non-owners during a burst are ignored: no op_ack, no state change. Their req stays pending and is considered in the next IDLE.
- op_ack, result_valid and grant are never asserted for a non-owner.
- result_ack bits for non-owners, or while not in RESULT, are ignored.
- A req[g] change during DRAIN or RESULT has no effect.
- Reset mid-operation: immediate return to reset values. The partial sum is discarded and no result is delivered.

Test Plan (TAPS=4, FRAC_BITS=10, NUM_REQ=2, DATA_WIDTH=32):
- Basic: req0 held high with a=1024, b=2048 for 4 pairs, result_ack tied high.
  - op_ack0 is high for exactly 4 cycles.
  - result=8192 with result_valid0 high, 5 cycles after grant0 rises.
  - grant1, op_ack1 and result_valid1 stay 0.
- Signed rounding: a=-1024, b=3 for 4 pairs -> result=-12 (0xFFFFFFF4).
  - Then a=-1, b=1 for 4 pairs -> result=0, because each product rounds toward zero.
- Round-robin: req0 and req1 both held high from reset.
  - Bursts are granted in order 0, 1, 0, 1.
  - There is exactly one IDLE cycle between the falling and rising grant edges.
  - op_ack is never high for the non-owner.
- Stall: req0 drops for 3 cycles after 2 acked pairs, then returns.
  - op_ack0 is low during the gap.
  - result is still 8192.
  - result_valid0 arrives 8 cycles after grant0.
- Wrap and hold: a=0x40000000, b=1024 for 4 pairs -> result=0x00000000 (2^32 wraps).
  - result_ack0 is held low for 5 cycles; result and result_valid0 stay stable throughout.
  - Acking frees the MAC: grant0 falls on the ack edge and a new burst can be granted after one IDLE cycle.
- Reset mid-burst: assert reset after 2 acked pairs.
  - grant, op_ack and result_valid go to 0 immediately.
  - After release with both requesting, requester 0 wins first and its next burst result excludes the discarded partial sum.

Source files
------------

// File: rtl/fir_mac_arbiter_if.sv
// Requester-side bus of the shared FIR MAC: operand pairs in, grant/ack and
// dot-product results out. The master modport is the FIR engine side, the
// slave modport is the arbiter.
interface fir_mac_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] a_in;
    logic [NUM_REQ*DATA_WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            op_ack;
    logic [DATA_WIDTH-1:0]         result;
    logic [NUM_REQ-1:0]            result_valid;
    logic [NUM_REQ-1:0]            result_ack;

    modport master (
        output req, a_in, b_in, result_ack,
        input  grant, op_ack, result, result_valid
    );

    modport slave (
        input  req, a_in, b_in, result_ack,
        output grant, op_ack, result, result_valid
    );
endinterface

// File: rtl/fir_mac_arbiter.sv
// Round-robin arbiter sharing one quantized multiply-accumulate datapath
// between NUM_REQ FIR engines. Each grant covers one burst of TAPS operand
// pairs; the burst's dot product is returned to the owner and held until it
// acknowledges.
module fir_mac_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int FRAC_BITS  = 10
) (
    input  logic              clock,
    input  logic              reset,
    fir_mac_arbiter_if.slave  bus
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;
    // Added to negative products before the shift so they round toward zero.
    localparam logic signed [PROD_W-1:0] ROUND_BIAS =
        (PROD_W'(1) << FRAC_BITS) - PROD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        RESULT
    } state_t;

    state_t                        state;
    logic [IDX_W-1:0]              owner;
    logic [IDX_W-1:0]              rr_ptr;
    logic [CNT_W-1:0]              tap_cnt;
    logic [DATA_WIDTH-1:0]         acc;
    logic [DATA_WIDTH-1:0]         prod_reg;
    logic                          prod_valid;
    logic [DATA_WIDTH-1:0]         result_r;
    logic [NUM_REQ-1:0]            grant_r;
    logic [NUM_REQ-1:0]            result_valid_r;
    logic [NUM_REQ-1:0]            op_ack_c;
    logic [IDX_W-1:0]              winner;
    logic                          found;
    int unsigned                   idx;
    logic signed [DATA_WIDTH-1:0]  a_sel;
    logic signed [DATA_WIDTH-1:0]  b_sel;

    // Full-width signed product, rounded toward zero, scaled down by FRAC_BITS.
    function automatic logic [DATA_WIDTH-1:0] dequantize(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        if (p < 0) begin
            p = p + ROUND_BIAS;
        end
        p = p >>> FRAC_BITS;
        return p[DATA_WIDTH-1:0];
    endfunction

    assign a_sel = bus.a_in[32'(owner) * DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = bus.b_in[32'(owner) * DATA_WIDTH +: DATA_WIDTH];

    assign bus.grant        = grant_r;
    assign bus.op_ack       = op_ack_c;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;

    // Round-robin pick: first requesting index at or above rr_ptr, wrapping.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && bus.req[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // The owner's pair is consumed whenever it presents one during MAC.
    always_comb begin
        op_ack_c = '0;
        if (state == MAC) begin
            op_ack_c[owner] = bus.req[owner];
        end
    end

    // Burst sequencing, product pipeline, accumulation and result handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= '0;
            rr_ptr         <= '0;
            tap_cnt        <= '0;
            acc            <= '0;
            prod_reg       <= '0;
            prod_valid     <= 1'b0;
            result_r       <= '0;
            grant_r        <= '0;
            result_valid_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner      <= winner;
                        grant_r    <= NUM_REQ'(1) << winner;
                        acc        <= '0;
                        tap_cnt    <= '0;
                        prod_valid <= 1'b0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    // Product registered last cycle is folded in now; a stall
                    // leaves prod_valid low so nothing is added twice.
                    if (prod_valid) begin
                        acc <= acc + prod_reg;
                    end
                    if (bus.req[owner]) begin
                        prod_reg   <= dequantize(a_sel, b_sel);
                        prod_valid <= 1'b1;
                        tap_cnt    <= tap_cnt + 1'b1;
                        if (tap_cnt == CNT_W'(TAPS - 1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        prod_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    acc            <= acc + prod_reg;
                    result_r       <= acc + prod_reg;
                    result_valid_r <= NUM_REQ'(1) << owner;
                    prod_valid     <= 1'b0;
                    state          <= RESULT;
                end
                RESULT: begin
                    if (bus.result_ack[owner]) begin
                        result_valid_r <= '0;
                        grant_r        <= '0;
                        rr_ptr         <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_arbiter.sv
// Self-checking bench for fir_mac_arbiter: directed bursts from the test plan
// followed by randomized bursts, checked against a dot-product / round-robin
// reference model.
module tb_fir_mac_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int DATA_WIDTH = 32;
    localparam int TAPS       = 4;
    localparam int FRAC_BITS  = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   av[TAPS];
    int   bv[TAPS];
    int   ptr_model = 0;

    fir_mac_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fir_mac_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .TAPS      (TAPS),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: each product divided by 2^FRAC_BITS with truncation toward
    // zero, summed modulo 2^32.
    function automatic logic [31:0] ref_dot();
        logic [31:0] sum;
        longint      p;
        longint      q;
        longint      scale;
        sum   = '0;
        scale = longint'(1) << FRAC_BITS;
        for (int i = 0; i < TAPS; i++) begin
            p   = longint'(av[i]) * longint'(bv[i]);
            q   = p / scale;
            sum = sum + 32'(q);
        end
        return sum;
    endfunction

    function automatic int rr_pick(input logic [1:0] reqs, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (reqs[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return ptr;
    endfunction

    function automatic int rnd_op();
        if ($urandom_range(0, 1) == 1) return int'($urandom);
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    task automatic drive_lane(input int r, input int a, input int b);
        bus.a_in[r*DATA_WIDTH +: DATA_WIDTH] = a;
        bus.b_in[r*DATA_WIDTH +: DATA_WIDTH] = b;
    endtask

    task automatic fill_const(input int a, input int b);
        for (int i = 0; i < TAPS; i++) begin
            av[i] = a;
            bv[i] = b;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < TAPS; i++) begin
            av[i] = rnd_op();
            bv[i] = rnd_op();
        end
    endtask

    // One burst for requester r. Expects req already presented so IDLE grants
    // on the next edge. ack_wait < 0 ties result_ack high; otherwise the ack
    // is withheld for ack_wait result-valid cycles. abort_at >= 0 pulses reset
    // after that many acked pairs. next_req is driven at the end so the
    // following IDLE sees it.
    task automatic run_burst(input int r, input bit other_req, input int stall_at,
                             input int stall_len, input int ack_wait,
                             input int abort_at, input logic [1:0] next_req);
        int          o;
        logic [31:0] exp_v;
        int          sent;
        int          stall_cnt;
        int          g_cycle;
        int          rv_cycle;
        int          rv_seen;
        bit          granted;
        bit          acking;
        bit          done;
        bit          stalling;
        logic        exp_ack;
        o         = 1 - r;
        exp_v     = ref_dot();
        sent      = 0;
        stall_cnt = 0;
        g_cycle   = -1;
        rv_cycle  = -1;
        rv_seen   = 0;
        granted   = 1'b0;
        acking    = 1'b0;
        done      = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clock);
            chk("nonowner_grant_rv", {bus.grant[o], bus.result_valid[o]}, 0);
            if (acking) begin
                chk("grant_release", bus.grant, 0);
                chk("rv_release", bus.result_valid, 0);
                chk("ack_count", sent, TAPS);
                bus.req        = next_req;
                bus.result_ack = '0;
                done           = 1'b1;
            end else begin
                if (!granted && bus.grant[r]) begin
                    granted = 1'b1;
                    g_cycle = t;
                    chk("grant_wait", t, 0);
                end
                if (granted) chk("grant_hold", bus.grant[r], 1);
                if (abort_at >= 0 && granted && sent == abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk("abort_grant", bus.grant, 0);
                    chk("abort_op_ack", bus.op_ack, 0);
                    chk("abort_rv", bus.result_valid, 0);
                    chk("abort_result", bus.result, 0);
                    @(negedge clock);
                    bus.req        = next_req;
                    bus.result_ack = '0;
                    reset          = 1'b0;
                    done           = 1'b1;
                end else begin
                    if (granted && bus.result_valid[r]) begin
                        if (rv_cycle < 0) begin
                            rv_cycle = t;
                            chk("latency", t - g_cycle, TAPS + 1 + ((stall_at >= 0) ? stall_len : 0));
                        end
                        chk("result", bus.result, exp_v);
                        rv_seen++;
                    end else begin
                        chk("rv_early", bus.result_valid[r], 0);
                    end
                    stalling = granted && (sent == stall_at) && (stall_cnt < stall_len);
                    if (sent < TAPS && !stalling) begin
                        bus.req[r] = 1'b1;
                        drive_lane(r, av[sent], bv[sent]);
                    end else if (sent < TAPS) begin
                        bus.req[r] = 1'b0;
                        drive_lane(r, rnd_op(), rnd_op());
                    end else begin
                        bus.req[r] = 1'($urandom);
                        drive_lane(r, rnd_op(), rnd_op());
                    end
                    if (stalling) stall_cnt++;
                    bus.req[o] = other_req;
                    drive_lane(o, rnd_op(), rnd_op());
                    bus.result_ack[o] = 1'($urandom);
                    if (ack_wait < 0) bus.result_ack[r] = 1'b1;
                    else              bus.result_ack[r] = (rv_seen > ack_wait);
                    acking = (rv_seen > 0) && bus.result_valid[r] && bus.result_ack[r];
                    #1;
                    exp_ack = granted && (sent < TAPS) && bus.req[r];
                    chk("op_ack", bus.op_ack[r], exp_ack);
                    chk("nonowner_op_ack", bus.op_ack[o], 0);
                    if (exp_ack) sent++;
                end
            end
        end
        if (!done) chk("burst_timeout", 1, 0);
    endtask

    initial begin
        logic [1:0] cur;
        logic [1:0] nxt;
        int         w;
        int         st_at;
        bus.req        = '0;
        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.result_ack = '0;

        // Reset state, with requests and acks present during reset.
        repeat (2) @(negedge clock);
        bus.req        = 2'b11;
        bus.result_ack = 2'b11;
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_op_ack", bus.op_ack, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_result", bus.result, 0);
        @(negedge clock);
        bus.req        = 2'b01;
        bus.result_ack = '0;
        reset          = 1'b0;

        // Basic: 1024*2048 over 4 taps, ack tied high.
        fill_const(1024, 2048);
        run_burst(0, 1'b0, -1, 0, -1, -1, 2'b01);
        // Signed rounding toward zero.
        fill_const(-1024, 3);
        run_burst(0, 1'b0, -1, 0, -1, -1, 2'b01);
        fill_const(-1, 1);
        run_burst(0, 1'b0, -1, 0, -1, -1, 2'b01);
        // Three-cycle stall after two pairs.
        fill_const(1024, 2048);
        run_burst(0, 1'b0, 2, 3, -1, -1, 2'b01);
        // Accumulator wrap, result held while ack withheld for 5 cycles.
        fill_const(32'h4000_0000, 1024);
        run_burst(0, 1'b0, -1, 0, 5, -1, 2'b11);
        // Pointer now favours requester 1; reset it away mid-burst.
        fill_rand();
        run_burst(1, 1'b1, -1, 0, -1, 2, 2'b11);
        ptr_model = 0;

        // Round-robin with both requesting: 0, 1, 0, 1.
        cur = 2'($urandom_range(1, 3));
        for (int k = 0; k < 4; k++) begin
            fill_rand();
            run_burst(k % 2, 1'b1, -1, 0, -1, -1, (k == 3) ? cur : 2'b11);
        end
        ptr_model = 0;

        // Randomized bursts: requester mix, operands, stalls, ack delays.
        for (int k = 0; k < 16; k++) begin
            nxt   = (k == 15) ? 2'b00 : 2'($urandom_range(1, 3));
            w     = rr_pick(cur, ptr_model);
            st_at = int'($urandom_range(0, 4)) - 1;
            fill_rand();
            run_burst(w, cur[1 - w], st_at, int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 4)) - 1, -1, nxt);
            ptr_model = (w + 1) % NUM_REQ;
            cur       = nxt;
        end

        repeat (3) @(negedge clock);
        chk("final_idle_grant", bus.grant, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
